cga_vram_arbiter: RTL

- Upstream neighbour of the CGA video core; owns the single shared VRAM port.
- Time-multiplexes sequencer video fetches with ISA CPU memory reads/writes to the B8000 window.
- Returns fetched bytes to the pixel pipeline, returns CPU read data, and generates bus wait states (cpu_rdy).
- Video fetches have absolute priority, so the display never glitches and never shows snow.

---
 rtl/cga_pkg.sv | 30 +++
 rtl/cga_strobe_sync.sv | 38 +++
 rtl/cga_vram_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cga_pkg.sv
// ============================================================================
// Module      : cga_pkg
// Description : Shared types and constants for the CGA VRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cga_pkg;

    localparam int          VRAM_AW     = 19;
    localparam logic [14:0] WIN16K_MASK = 15'h3FFF;
    localparam logic [14:0] WIN32K_MASK = 15'h7FFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU_ADDR = 3'd1,
        CPU_RD   = 3'd2,
        CPU_WR   = 3'd3,
        CPU_HOLD = 3'd4
    } cga_state_e;

    // The 16K window aliases every 0x4000 bytes, so bit 14 is dropped there.
    function automatic logic [VRAM_AW-1:0] cpu_vram_addr(input logic [14:0] a,
                                                          input logic        tandy);
        return {4'b0000, a & (tandy ? WIN32K_MASK : WIN16K_MASK)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cga_strobe_sync.sv
// ============================================================================
// Module      : cga_strobe_sync
// Description : SYNC_STAGES-deep synchroniser and falling-edge detector for
//               an active-low ISA strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cga_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_l,
    input  logic strobe_l,
    output logic synced_l,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Flops reset to the inactive (high) level so reset release is not an edge.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], strobe_l};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign synced_l = r_sync[SYNC_STAGES-1];
    assign fall     = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/cga_vram_arbiter.sv
// ============================================================================
// Module      : cga_vram_arbiter
// Description : Shares the single VRAM port between sequencer video fetches
//               (absolute priority) and ISA CPU reads/writes. Optional
//               posted-write buffer enabled by macro CGA_POSTED_WRITE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cga_vram_arbiter
    import cga_pkg::*;
#(
    parameter int USE_BUS_WAIT = 1,
    parameter int WE_CYCLES    = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               clk,
    input  logic               reset_l,
    input  logic [14:0]        bus_a,
    input  logic               bus_memr_l,
    input  logic               bus_memw_l,
    input  logic [7:0]         bus_d,
    output logic [7:0]         bus_out,
    output logic               bus_rdy,
    input  logic               tandy_mode,
    input  logic               vid_req,
    input  logic [VRAM_AW-1:0] vid_addr,
    output logic [7:0]         vid_data,
    output logic               vid_valid,
    output logic [VRAM_AW-1:0] ram_a,
    input  logic [7:0]         ram_d,
    output logic [7:0]         ram_dout,
    output logic               ram_we_l
);

    cga_state_e         r_state, w_next;
    logic               w_rd_fall, w_wr_fall, w_rd_sync_l, w_wr_sync_l;
    logic               r_pend;
    logic [VRAM_AW-1:0] r_pend_addr;
    logic               r_op_wr;
    logic [2:0]         r_we_cnt;
    logic               r_vid_pend;
    logic               r_stall_v;
    logic [VRAM_AW-1:0] r_stall_addr;
    logic [VRAM_AW-1:0] w_cpu_addr;
    logic               w_vid_busy, w_vid_slot, w_we_last, w_rd_done, w_wr_done;
    logic               w_go, w_go_wr, w_wait;
    logic [VRAM_AW-1:0] w_go_addr;
    logic [7:0]         w_go_data;

    cga_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
        .clk      (clk),
        .reset_l  (reset_l),
        .strobe_l (bus_memr_l),
        .synced_l (w_rd_sync_l),
        .fall     (w_rd_fall)
    );

    cga_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
        .clk      (clk),
        .reset_l  (reset_l),
        .strobe_l (bus_memw_l),
        .synced_l (w_wr_sync_l),
        .fall     (w_wr_fall)
    );

    assign w_cpu_addr = cpu_vram_addr(bus_a, tandy_mode);
    assign w_vid_busy = vid_req | r_stall_v;
    assign w_vid_slot = (r_state == IDLE) || (r_state == CPU_HOLD);
    assign w_we_last  = (r_we_cnt == 3'(WE_CYCLES - 1));
    assign w_rd_done  = (r_state == CPU_RD);
    assign w_wr_done  = (r_state == CPU_WR) && w_we_last;

`ifdef CGA_POSTED_WRITE_EN
    logic               r_buf_full, r_wwait;
    logic [VRAM_AW-1:0] r_buf_addr, r_wwait_addr;
    logic [7:0]         r_buf_data, r_wwait_data;
    logic               w_buf_free;

    // A buffer finishing its drain this cycle can take a new write directly.
    assign w_buf_free = !r_buf_full || (w_wr_done && !r_wwait);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_pend       <= 1'b0;
            r_pend_addr  <= '0;
            r_buf_full   <= 1'b0;
            r_buf_addr   <= '0;
            r_buf_data   <= '0;
            r_wwait      <= 1'b0;
            r_wwait_addr <= '0;
            r_wwait_data <= '0;
        end else begin
            if (w_rd_fall && !w_wr_fall && !r_pend) begin
                r_pend      <= 1'b1;
                r_pend_addr <= w_cpu_addr;
            end else if (w_rd_done) begin
                r_pend <= 1'b0;
            end
            if (w_wr_done) begin
                if (r_wwait) begin
                    r_buf_addr <= r_wwait_addr;
                    r_buf_data <= r_wwait_data;
                    r_wwait    <= 1'b0;
                end else begin
                    r_buf_full <= 1'b0;
                end
            end
            if (w_wr_fall) begin
                if (w_buf_free) begin
                    r_buf_full <= 1'b1;
                    r_buf_addr <= w_cpu_addr;
                    r_buf_data <= bus_d;
                end else if (!r_wwait) begin
                    r_wwait      <= 1'b1;
                    r_wwait_addr <= w_cpu_addr;
                    r_wwait_data <= bus_d;
                end
            end
        end
    end

    // Buffered write always goes first so a later read sees it.
    assign w_go      = r_buf_full | r_pend;
    assign w_go_wr   = r_buf_full;
    assign w_go_addr = r_buf_full ? r_buf_addr : r_pend_addr;
    assign w_go_data = r_buf_data;
    assign w_wait    = r_pend | r_wwait;
`else
    logic       r_pend_wr;
    logic [7:0] r_pend_data;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_pend      <= 1'b0;
            r_pend_wr   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else if (!r_pend && (w_rd_fall || w_wr_fall)) begin
            r_pend      <= 1'b1;
            r_pend_wr   <= w_wr_fall;
            r_pend_addr <= w_cpu_addr;
            r_pend_data <= bus_d;
        end else if (w_rd_done || w_wr_done) begin
            r_pend <= 1'b0;
        end
    end

    assign w_go      = r_pend;
    assign w_go_wr   = r_pend_wr;
    assign w_go_addr = r_pend_addr;
    assign w_go_data = r_pend_data;
    assign w_wait    = r_pend;
`endif

    generate
        if (USE_BUS_WAIT != 0) begin : g_bus_wait
            assign bus_rdy = ~w_wait;
        end else begin : g_no_bus_wait
            assign bus_rdy = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (w_go && !w_vid_busy) w_next = CPU_ADDR;
            CPU_ADDR: w_next = r_op_wr ? CPU_WR : CPU_RD;
            CPU_RD:   w_next = CPU_HOLD;
            CPU_WR:   if (w_we_last) w_next = CPU_HOLD;
            // Only the strobe of the finished access matters here.
            CPU_HOLD: if (r_op_wr ? w_wr_sync_l : w_rd_sync_l) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            ram_a        <= '0;
            ram_we_l     <= 1'b1;
            ram_dout     <= '0;
            bus_out      <= '0;
            vid_data     <= '0;
            vid_valid    <= 1'b0;
            r_vid_pend   <= 1'b0;
            r_stall_v    <= 1'b0;
            r_stall_addr <= '0;
            r_op_wr      <= 1'b0;
            r_we_cnt     <= '0;
        end else begin
            vid_valid  <= r_vid_pend;
            r_vid_pend <= 1'b0;
            if (r_vid_pend) vid_data <= ram_d;

            if (w_vid_slot) begin
                if (r_stall_v) begin
                    ram_a        <= r_stall_addr;
                    r_vid_pend   <= 1'b1;
                    r_stall_v    <= vid_req;
                    r_stall_addr <= vid_addr;
                end else if (vid_req) begin
                    ram_a      <= vid_addr;
                    r_vid_pend <= 1'b1;
                end else if ((r_state == IDLE) && w_go) begin
                    ram_a   <= w_go_addr;
                    r_op_wr <= w_go_wr;
                    if (w_go_wr) ram_dout <= w_go_data;
                end
            end else if (vid_req) begin
                r_stall_v    <= 1'b1;
                r_stall_addr <= vid_addr;
            end

            if ((r_state == CPU_ADDR) && r_op_wr) begin
                ram_we_l <= 1'b0;
                r_we_cnt <= '0;
            end else if (r_state == CPU_WR) begin
                if (w_we_last) ram_we_l <= 1'b1;
                else           r_we_cnt <= r_we_cnt + 3'd1;
            end

            if (r_state == CPU_RD) bus_out <= ram_d;
        end
    end

endmodule

`default_nettype wire
